// File: rtl/fifo_memory.sv
// Single-clock FIFO (DEPTH x DATA_WIDTH) with full/empty/threshold status and sticky
// overflow/underflow error flags. Reset is synchronous and active-high on rst_n.
module fifo_memory #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int THRESHOLD  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic                  rd,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic                  fifo_threshold,
    output logic                  fifo_overflow,
    output logic                  fifo_underflow
);

    localparam logic [ADDR_WIDTH:0] LP_ONE    = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] LP_THRESH = (ADDR_WIDTH + 1)'(THRESHOLD);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH:0]   r_wptr;
    logic [ADDR_WIDTH:0]   r_rptr;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [ADDR_WIDTH:0]   w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_ok;
    logic                  w_wr_ok;

    // The extra pointer MSB distinguishes a full ring from an empty one.
    assign w_count = r_wptr - r_rptr;
    assign w_full  = (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]) &&
                     (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]);
    assign w_empty = (r_wptr == r_rptr);

    // A read on a full FIFO frees the slot the simultaneous write lands in.
    assign w_rd_ok = rd && !w_empty;
    assign w_wr_ok = wr && (!w_full || w_rd_ok);

    // NOTE: storage has no reset so it maps onto plain RAM; stale contents are never
    // observable because the pointers are cleared instead.
    always_ff @(posedge clk) begin
        if (!rst_n && w_wr_ok) begin
            r_mem[r_wptr[ADDR_WIDTH-1:0]] <= data_in;
        end
    end

    // NOTE: all state here uses non-blocking assignments so every flag sees the
    // pre-edge pointer values, regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_data_out  <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_wptr      <= r_wptr + LP_ONE;
                r_underflow <= 1'b0;
            end else if (rd && w_empty && !wr) begin
                r_underflow <= 1'b1;
            end

            if (w_rd_ok) begin
                r_data_out <= r_mem[r_rptr[ADDR_WIDTH-1:0]];
                r_rptr     <= r_rptr + LP_ONE;
                r_overflow <= 1'b0;
            end else if (wr && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign data_out       = r_data_out;
    assign fifo_full      = w_full;
    assign fifo_empty     = w_empty;
    assign fifo_threshold = (w_count >= LP_THRESH);
    assign fifo_overflow  = r_overflow;
    assign fifo_underflow = r_underflow;

endmodule

// File: tb/tb_fifo_memory.sv
// Bench for fifo_memory: a queue model predicts flags each cycle, and read data is
// checked through an expected-value scoreboard drained by a separate monitor.
module tb_fifo_memory;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] data_out;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_threshold;
    logic       fifo_overflow;
    logic       fifo_underflow;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] m_q[$];
    logic [7:0] q_exp[$];
    logic       m_over;
    logic       m_under;
    logic [7:0] m_dout;

    fifo_memory dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wr             (wr),
        .rd             (rd),
        .data_in        (data_in),
        .data_out       (data_out),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .fifo_threshold (fifo_threshold),
        .fifo_overflow  (fifo_overflow),
        .fifo_underflow (fifo_underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every read request is matched against the value the driver predicted.
    always @(posedge clk) begin
        if (rd && !rst_n) begin
            #1;
            if (q_exp.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL scoreboard_empty: got %h expected <none queued>", data_out);
            end else begin
                check("sb_data_out", data_out, q_exp.pop_front());
            end
        end
    end

    // Drive one cycle starting from a falling edge, update the model, check flags after.
    task automatic cycle(input logic i_rst, input logic i_wr, input logic i_rd,
                         input logic [7:0] i_din, input string tag);
        logic full;
        logic empty;
        logic rd_ok;
        logic wr_ok;
        rst_n   = i_rst;
        wr      = i_wr;
        rd      = i_rd;
        data_in = i_din;
        if (i_rst) begin
            m_q.delete();
            m_over  = 1'b0;
            m_under = 1'b0;
            m_dout  = 8'h00;
        end else begin
            full  = (m_q.size() == 16);
            empty = (m_q.size() == 0);
            rd_ok = i_rd && !empty;
            wr_ok = i_wr && (!full || rd_ok);
            if (rd_ok) begin
                m_dout = m_q.pop_front();
                m_over = 1'b0;
            end
            if (wr_ok) begin
                m_q.push_back(i_din);
                m_under = 1'b0;
            end
            if (i_wr && full && !rd_ok) m_over = 1'b1;
            if (i_rd && empty && !i_wr) m_under = 1'b1;
            if (i_rd) q_exp.push_back(m_dout);
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, "/empty"}, {7'b0, fifo_empty}, {7'b0, m_q.size() == 0});
        check({tag, "/full"}, {7'b0, fifo_full}, {7'b0, m_q.size() == 16});
        check({tag, "/threshold"}, {7'b0, fifo_threshold}, {7'b0, m_q.size() >= 8});
        check({tag, "/overflow"}, {7'b0, fifo_overflow}, {7'b0, m_over});
        check({tag, "/underflow"}, {7'b0, fifo_underflow}, {7'b0, m_under});
        if (i_rst || !i_rd) check({tag, "/data_hold"}, data_out, m_dout);
    endtask

    task automatic do_wr(input logic [7:0] v);
        cycle(1'b0, 1'b1, 1'b0, v, "wr");
    endtask

    task automatic do_rd();
        cycle(1'b0, 1'b0, 1'b1, 8'h00, "rd");
    endtask

    task automatic do_rw(input logic [7:0] v);
        cycle(1'b0, 1'b1, 1'b1, v, "rw");
    endtask

    initial begin
        cycle(1'b1, 1'b0, 1'b0, 8'h00, "reset");
        cycle(1'b1, 1'b0, 1'b0, 8'h00, "reset");
        cycle(1'b0, 1'b0, 1'b0, 8'h00, "idle");
        check("rst_empty", {7'b0, fifo_empty}, 8'h01);
        check("rst_full", {7'b0, fifo_full}, 8'h00);
        check("rst_threshold", {7'b0, fifo_threshold}, 8'h00);
        check("rst_data_out", data_out, 8'h00);

        // Fill 0x01..0x10, then one write too many.
        for (int i = 1; i <= 16; i++) begin
            do_wr(8'(i));
            if (i == 1)  check("empty_after_w1", {7'b0, fifo_empty}, 8'h00);
            if (i == 7)  check("thr_after_w7", {7'b0, fifo_threshold}, 8'h00);
            if (i == 8)  check("thr_after_w8", {7'b0, fifo_threshold}, 8'h01);
            if (i == 15) check("full_after_w15", {7'b0, fifo_full}, 8'h00);
            if (i == 16) check("full_after_w16", {7'b0, fifo_full}, 8'h01);
        end
        do_wr(8'h11);
        check("ovf_after_w17", {7'b0, fifo_overflow}, 8'h01);
        check("full_after_w17", {7'b0, fifo_full}, 8'h01);

        // Drain 16 entries in order, then one read too many.
        for (int i = 1; i <= 16; i++) begin
            do_rd();
            check("drain_data", data_out, 8'(i));
            if (i == 1)  check("ovf_after_r1", {7'b0, fifo_overflow}, 8'h00);
            if (i == 1)  check("full_after_r1", {7'b0, fifo_full}, 8'h00);
            if (i == 8)  check("thr_at_cnt8", {7'b0, fifo_threshold}, 8'h01);
            if (i == 9)  check("thr_at_cnt7", {7'b0, fifo_threshold}, 8'h00);
            if (i == 16) check("empty_after_r16", {7'b0, fifo_empty}, 8'h01);
        end
        do_rd();
        check("unf_after_r17", {7'b0, fifo_underflow}, 8'h01);
        check("data_after_r17", data_out, 8'h10);

        // Reset mid-stream discards stored data.
        do_wr(8'h55);
        do_wr(8'h66);
        do_wr(8'h77);
        cycle(1'b1, 1'b1, 1'b1, 8'hEE, "mid_reset");
        check("midrst_empty", {7'b0, fifo_empty}, 8'h01);
        check("midrst_data", data_out, 8'h00);
        check("midrst_unf", {7'b0, fifo_underflow}, 8'h00);
        do_wr(8'h99);
        do_rd();
        check("midrst_first_out", data_out, 8'h99);

        // Pointer wrap-around.
        for (int i = 0; i < 10; i++) do_wr(8'(8'h20 + i));
        for (int i = 0; i < 10; i++) do_rd();
        check("wrap_a_last", data_out, 8'h29);
        for (int i = 0; i < 12; i++) do_wr(8'(8'h40 + i));
        for (int i = 0; i < 12; i++) do_rd();
        check("wrap_b_last", data_out, 8'h4B);

        // Simultaneous wr+rd at count 5.
        for (int i = 0; i < 5; i++) do_wr(8'(8'h60 + i));
        for (int i = 0; i < 3; i++) do_rw(8'(8'h70 + i));
        for (int i = 0; i < 5; i++) do_rd();
        check("rw5_last", data_out, 8'h72);
        check("rw5_empty", {7'b0, fifo_empty}, 8'h01);

        // Simultaneous wr+rd while full.
        for (int i = 0; i < 16; i++) do_wr(8'(8'h80 + i));
        do_rw(8'hA0);
        check("rwfull_full", {7'b0, fifo_full}, 8'h01);
        check("rwfull_ovf", {7'b0, fifo_overflow}, 8'h00);
        check("rwfull_data", data_out, 8'h80);
        for (int i = 0; i < 16; i++) do_rd();
        check("rwfull_last", data_out, 8'hA0);

        // Simultaneous wr+rd while empty.
        do_rw(8'hB0);
        check("rwempty_empty", {7'b0, fifo_empty}, 8'h00);
        check("rwempty_unf", {7'b0, fifo_underflow}, 8'h00);
        check("rwempty_data", data_out, 8'hA0);
        do_rd();
        check("rwempty_out", data_out, 8'hB0);

        // Underflow clears on the next accepted write.
        do_rd();
        check("unf_set", {7'b0, fifo_underflow}, 8'h01);
        do_wr(8'hAA);
        check("unf_clear", {7'b0, fifo_underflow}, 8'h00);
        check("unf_clear_empty", {7'b0, fifo_empty}, 8'h00);
        do_rd();
        check("unf_read_aa", data_out, 8'hAA);

        cycle(1'b0, 1'b0, 1'b0, 8'h00, "idle");
        cycle(1'b0, 1'b0, 1'b0, 8'h00, "idle");
        check("scoreboard_drained", 8'(q_exp.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
